// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator with a valid/ready handshake on both sides.
// It decodes Save-PC and Addi immediates and keeps a saturating count of unknown opcodes delivered.
module imm_gen_pipe #(
  parameter int                 INST_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter int                 OPC_W      = 4,
  parameter logic [OPC_W-1:0]   SPC_OPC    = 4'b1111,
  parameter int                 SPC_IMM_W  = 22,
  parameter logic [OPC_W-1:0]   ADDI_OPC   = 4'b0101,
  parameter int                 ADDI_IMM_W = 16,
  parameter int                 CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_zext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [1:0]        out_kind,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_clr
);

  localparam int FLD_W = (SPC_IMM_W > ADDI_IMM_W) ? SPC_IMM_W : ADDI_IMM_W;
  localparam logic [DATA_W-1:0] SPC_MASK  = ~({DATA_W{1'b1}} << SPC_IMM_W);
  localparam logic [DATA_W-1:0] ADDI_MASK = ~({DATA_W{1'b1}} << ADDI_IMM_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    KIND_UNK  = 2'b00,
    KIND_SPC  = 2'b01,
    KIND_ADDI = 2'b10
  } kind_t;

  logic [OPC_W-1:0]  opc;
  kind_t             dec_kind;
  logic [FLD_W-1:0]  dec_field;
  logic              dec_sign;

  logic              s1_valid;
  kind_t             s1_kind;
  logic [FLD_W-1:0]  s1_field;
  logic              s1_sign;

  logic              s2_valid;
  kind_t             s2_kind;
  logic [DATA_W-1:0] fld_wide;
  logic [DATA_W-1:0] ext_imm;

  logic              in_fire;
  logic              out_fire;
  logic              s2_load;

  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s2_valid && out_ready;
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign out_valid = s2_valid;
  assign out_kind  = s2_kind;

  assign opc = in_inst[INST_W-1 -: OPC_W];

  // The sign bit is resolved here so in_zext travels with its own instruction.
  always_comb begin
    dec_kind  = KIND_UNK;
    dec_field = '0;
    dec_sign  = 1'b0;
    if (opc == SPC_OPC) begin
      dec_kind                   = KIND_SPC;
      dec_field[SPC_IMM_W-1:0]   = in_inst[SPC_IMM_W-1:0];
      dec_sign                   = !in_zext && in_inst[SPC_IMM_W-1];
    end else if (opc == ADDI_OPC) begin
      dec_kind                   = KIND_ADDI;
      dec_field[ADDI_IMM_W-1:0]  = in_inst[ADDI_IMM_W-1:0];
      dec_sign                   = !in_zext && in_inst[ADDI_IMM_W-1];
    end
  end

  assign fld_wide = DATA_W'(s1_field);

  always_comb begin
    ext_imm = '0;
    case (s1_kind)
      KIND_SPC:  ext_imm = (fld_wide & SPC_MASK)  | (s1_sign ? ~SPC_MASK  : '0);
      KIND_ADDI: ext_imm = (fld_wide & ADDI_MASK) | (s1_sign ? ~ADDI_MASK : '0);
      default:   ext_imm = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_kind  <= KIND_UNK;
      s1_field <= '0;
      s1_sign  <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_kind  <= dec_kind;
      s1_field <= dec_field;
      s1_sign  <= dec_sign;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Output registers only change on a load, so a stalled item stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_kind  <= KIND_UNK;
      out_imm  <= '0;
      out_err  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_kind  <= s1_kind;
      out_imm  <= ext_imm;
      out_err  <= (s1_kind == KIND_UNK);
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_fire && out_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors, error counting, throughput,
// backpressure, counter saturation (CNT_W=2) and reset in mid-stream.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        in_zext;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [1:0]  out_kind;
  logic        out_err;
  logic [1:0]  err_cnt;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_zext(in_zext),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_kind(out_kind), .out_err(out_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_imm !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_imm: got %h expected 00000000", out_imm); end
    checks++; if (out_kind !== 2'b00) begin errors++; $display("[TB] FAIL reset_out_kind: got %b expected 00", out_kind); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_err: got %b expected 0", out_err); end
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_out_valid: got %b expected 0", out_valid); end
  endtask

  // Each vector is accepted, then in_zext is flipped so an in-flight item must ignore it.
  task automatic test_decode_single();
    logic [31:0] insts [5] = '{32'hF0200005, 32'hF0200005, 32'h5000FFFF, 32'h50007FFF, 32'h5000FFFF};
    logic        zexts [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] imms  [5] = '{32'hFFE00005, 32'h00200005, 32'hFFFFFFFF, 32'h00007FFF, 32'h0000FFFF};
    logic [1:0]  kinds [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_inst = insts[i]; in_zext = zexts[i];
      step();
      in_valid = 1'b0; in_inst = 32'h0; in_zext = ~zexts[i];
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL decode%0d_early_valid: got %b expected 0", i, out_valid); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL decode%0d_valid: got %b expected 1", i, out_valid); end
      checks++; if (out_imm !== imms[i]) begin errors++; $display("[TB] FAIL decode%0d_imm: got %h expected %h", i, out_imm, imms[i]); end
      checks++; if (out_kind !== kinds[i]) begin errors++; $display("[TB] FAIL decode%0d_kind: got %b expected %b", i, out_kind, kinds[i]); end
      checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL decode%0d_err: got %b expected 0", i, out_err); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL decode%0d_drain: got %b expected 0", i, out_valid); end
    end
    in_zext = 1'b0;
  endtask

  task automatic test_unknown_and_clear();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h30000000;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL unk_valid: got %b expected 1", out_valid); end
    checks++; if (out_imm !== 32'h0) begin errors++; $display("[TB] FAIL unk_imm: got %h expected 00000000", out_imm); end
    checks++; if (out_kind !== 2'b00) begin errors++; $display("[TB] FAIL unk_kind: got %b expected 00", out_kind); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("[TB] FAIL unk_err: got %b expected 1", out_err); end
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL unk_cnt_before: got %0d expected 0", err_cnt); end
    step();
    checks++; if (err_cnt !== 2'd1) begin errors++; $display("[TB] FAIL unk_cnt_after: got %0d expected 1", err_cnt); end
    in_valid = 1'b1; in_inst = 32'h30000000;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_err !== 1'b1) begin errors++; $display("[TB] FAIL unk2_err: got %b expected 1", out_err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL clr_wins: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [3] = '{32'h50000001, 32'h50008000, 32'hF0000003};
    logic [31:0] imms  [3] = '{32'h00000001, 32'hFFFF8000, 32'h00000003};
    logic [1:0]  kinds [3] = '{2'b10, 2'b10, 2'b01};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        in_valid = 1'b1; in_inst = insts[k];
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b%0d_in_ready: got %b expected 1", k, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1 && k <= 3) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b%0d_valid: got %b expected 1", k, out_valid); end
        checks++; if (out_imm !== imms[k-1]) begin errors++; $display("[TB] FAIL b2b%0d_imm: got %h expected %h", k, out_imm, imms[k-1]); end
        checks++; if (out_kind !== kinds[k-1]) begin errors++; $display("[TB] FAIL b2b%0d_kind: got %b expected %b", k, out_kind, kinds[k-1]); end
      end
      if (k == 4) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h50000011;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_one: got %b expected 1", in_ready); end
    in_inst = 32'h50000022;
    step();
    in_inst = 32'h5000F033; in_zext = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full: got %b expected 0", in_ready); end
    for (int s = 0; s < 2; s++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall%0d_valid: got %b expected 1", s, out_valid); end
      checks++; if (out_imm !== 32'h00000011) begin errors++; $display("[TB] FAIL bp_stall%0d_imm: got %h expected 00000011", s, out_imm); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall%0d_ready: got %b expected 0", s, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_release: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0; in_zext = 1'b0;
    checks++; if (out_imm !== 32'h00000022) begin errors++; $display("[TB] FAIL bp_second: got %h expected 00000022", out_imm); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_third_valid: got %b expected 1", out_valid); end
    checks++; if (out_imm !== 32'h0000F033) begin errors++; $display("[TB] FAIL bp_third: got %h expected 0000F033", out_imm); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL sat_start: got %0d expected 0", err_cnt); end
    out_ready = 1'b1;
    for (int s = 1; s <= 7; s++) begin
      in_valid = (s <= 5);
      in_inst = 32'h30000000 | s;
      step();
      if (s >= 3) begin
        checks++; if (err_cnt !== exp_cnt[s]) begin errors++; $display("[TB] FAIL sat_step%0d: got %0d expected %0d", s, err_cnt, exp_cnt[s]); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h30000001;
    step();
    in_inst = 32'h30000002;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_inflight: got %b expected 1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL mid_err_cnt: got %0d expected 0", err_cnt); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_err: got %b expected 0", out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale%0d: got %b expected 0", s, out_valid); end
      checks++; if (err_cnt !== 2'd0) begin errors++; $display("[TB] FAIL mid_cnt%0d: got %0d expected 0", s, err_cnt); end
    end
    in_valid = 1'b1; in_inst = 32'h50000042;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_valid: got %b expected 1", out_valid); end
    checks++; if (out_imm !== 32'h00000042) begin errors++; $display("[TB] FAIL post_imm: got %h expected 00000042", out_imm); end
    checks++; if (out_kind !== 2'b10) begin errors++; $display("[TB] FAIL post_kind: got %b expected 10", out_kind); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_zext = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_decode_single();
    test_unknown_and_clear();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
